// File: rtl/cramer3_seq_ctrl_if.sv
// Handshake and operand/result bundle between the operand source, the
// Cramer's-rule controller and the downstream display logic.
interface cramer3_seq_ctrl_if #(
  parameter int W = 12
);
  localparam int DW = 3 * W + 2;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  a11, a12, a13;
  logic signed [W-1:0]  a21, a22, a23;
  logic signed [W-1:0]  a31, a32, a33;
  logic signed [W-1:0]  c1, c2, c3;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x, y, z;
  logic                 singular;
  logic                 busy;

  // Operand source / result consumer side
  modport master (
    output in_valid, a11, a12, a13, a21, a22, a23, a31, a32, a33, c1, c2, c3,
    output out_ready,
    input  in_ready, out_valid, x, y, z, singular, busy
  );

  // Controller side
  modport slave (
    input  in_valid, a11, a12, a13, a21, a22, a23, a31, a32, a33, c1, c2, c3,
    input  out_ready,
    output in_ready, out_valid, x, y, z, singular, busy
  );
endinterface

// File: rtl/cramer3_seq_ctrl.sv
// Sequential 3x3 Cramer's-rule solver: one shared 2x2-minor/MAC step per
// cycle builds D, Dx, Dy, Dz, then one restoring divider produces x, y, z.
module cramer3_seq_ctrl #(
  parameter int W = 12
) (
  input  logic              clk,
  input  logic              rst,
  cramer3_seq_ctrl_if.slave bus
);
  localparam int DW = 3 * W + 2;
  localparam int PW = 2 * W;
  localparam int MW = 2 * W + 1;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [2:0] {IDLE, MINOR, CHECK, DIV, DONE} state_t;

  state_t state, state_next;

  logic signed [W-1:0]  a_r [3][3];
  logic signed [W-1:0]  c_r [3];
  logic signed [DW-1:0] acc [4];
  logic [1:0]           grp;
  logic [1:0]           term;

  logic signed [W-1:0]  gm [3][3];
  logic signed [W-1:0]  row1_e, r2p, r2q, r3p, r3q;
  logic signed [PW-1:0] prod_pq, prod_qp;
  logic signed [MW-1:0] minor;
  logic signed [DW-1:0] term_val;

  logic [DW-1:0]        rem, quo, dvs;
  logic                 neg;
  logic [CW-1:0]        bit_cnt;
  logic [1:0]           div_sel;
  logic [1:0]           nxt_idx;
  logic [DW:0]          rem_sh, rem_sub;
  logic [DW-1:0]        rem_next, quo_next;
  logic signed [DW-1:0] q_signed;

  logic signed [DW-1:0] x_r, y_r, z_r;
  logic                 singular_r;

  logic                 d_zero;
  logic                 div_last;

  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  assign d_zero   = (acc[0] == '0);
  assign div_last = (bit_cnt == LAST_BIT);
  assign nxt_idx  = div_sel + 2'd2;

  // Select the current group matrix, pick the minor operands for this term and form the signed MAC term
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int col = 0; col < 3; col++) begin
        gm[r][col] = (grp != 2'd0 && int'(grp) == col + 1) ? c_r[r] : a_r[r][col];
      end
    end
    row1_e = gm[0][0];
    r2p    = gm[1][1];
    r2q    = gm[1][2];
    r3p    = gm[2][1];
    r3q    = gm[2][2];
    case (term)
      2'd1: begin
        row1_e = gm[0][1];
        r2p    = gm[1][0];
        r2q    = gm[1][2];
        r3p    = gm[2][0];
        r3q    = gm[2][2];
      end
      2'd2: begin
        row1_e = gm[0][2];
        r2p    = gm[1][0];
        r2q    = gm[1][1];
        r3p    = gm[2][0];
        r3q    = gm[2][1];
      end
      default: ;
    endcase
    prod_pq  = PW'(r2p) * PW'(r3q);
    prod_qp  = PW'(r2q) * PW'(r3p);
    minor    = MW'(prod_pq) - MW'(prod_qp);
    term_val = DW'(row1_e) * DW'(minor);
  end

  // One restoring-division step on magnitudes, then re-apply the quotient sign
  always_comb begin
    rem_sh   = {rem, quo[DW-1]};
    rem_sub  = rem_sh - {1'b0, dvs};
    rem_next = rem_sub[DW] ? rem_sh[DW-1:0] : rem_sub[DW-1:0];
    quo_next = {quo[DW-2:0], ~rem_sub[DW]};
    q_signed = neg ? -signed'(quo_next) : signed'(quo_next);
  end

  // Next-state logic for the IDLE -> MINOR -> CHECK -> DIV -> DONE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = MINOR;
      MINOR:   if (grp == 2'd3 && term == 2'd2) state_next = CHECK;
      CHECK:   state_next = d_zero ? DONE : DIV;
      DIV:     if (div_last && div_sel == 2'd2) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture operands on accept, then accumulate one signed cofactor term per MINOR cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_r[0][0] <= bus.a11; a_r[0][1] <= bus.a12; a_r[0][2] <= bus.a13;
      a_r[1][0] <= bus.a21; a_r[1][1] <= bus.a22; a_r[1][2] <= bus.a23;
      a_r[2][0] <= bus.a31; a_r[2][1] <= bus.a32; a_r[2][2] <= bus.a33;
      c_r[0] <= bus.c1;
      c_r[1] <= bus.c2;
      c_r[2] <= bus.c3;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      grp  <= 2'd0;
      term <= 2'd0;
    end else if (state == MINOR) begin
      if (term == 2'd1) acc[grp] <= acc[grp] - term_val;
      else              acc[grp] <= acc[grp] + term_val;
      if (term == 2'd2) begin
        term <= 2'd0;
        grp  <= grp + 2'd1;
      end else begin
        term <= term + 2'd1;
      end
    end
  end

  // Divider sequencing: load Dx/D at CHECK, then chain Dy/D and Dz/D as each finishes
  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      rem     <= '0;
      quo     <= mag(acc[1]);
      dvs     <= mag(acc[0]);
      neg     <= acc[1][DW-1] ^ acc[0][DW-1];
      bit_cnt <= '0;
      div_sel <= 2'd0;
    end else if (state == DIV) begin
      if (div_last) begin
        rem     <= '0;
        quo     <= mag(acc[nxt_idx]);
        neg     <= acc[nxt_idx][DW-1] ^ acc[0][DW-1];
        bit_cnt <= '0;
        div_sel <= div_sel + 2'd1;
      end else begin
        rem     <= rem_next;
        quo     <= quo_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Result registers: singular short-cut at CHECK, quotients written as each division completes
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      singular_r <= 1'b0;
    end else if (state == CHECK) begin
      singular_r <= d_zero;
      if (d_zero) begin
        x_r <= '0;
        y_r <= '0;
        z_r <= '0;
      end
    end else if (state == DIV && div_last) begin
      case (div_sel)
        2'd0:    x_r <= q_signed;
        2'd1:    y_r <= q_signed;
        default: z_r <= q_signed;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.x         = x_r;
  assign bus.y         = y_r;
  assign bus.z         = z_r;
  assign bus.singular  = singular_r;

endmodule

// File: tb/tb_cramer3_seq_ctrl.sv
// Directed-vector bench for cramer3_seq_ctrl with hand-computed solutions.
module tb_cramer3_seq_ctrl;
  localparam int W  = 12;
  localparam int DW = 3 * W + 2;

  typedef int vec12_t [12];

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat;

  vec12_t t_basic, t_sing, t_trunc, t_full;

  always #5 clk = ~clk;

  cramer3_seq_ctrl_if #(.W(W)) bus ();

  cramer3_seq_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic load_ports(input vec12_t v);
    bus.a11 = v[0][W-1:0];  bus.a12 = v[1][W-1:0];  bus.a13 = v[2][W-1:0];
    bus.a21 = v[3][W-1:0];  bus.a22 = v[4][W-1:0];  bus.a23 = v[5][W-1:0];
    bus.a31 = v[6][W-1:0];  bus.a32 = v[7][W-1:0];  bus.a33 = v[8][W-1:0];
    bus.c1  = v[9][W-1:0];  bus.c2  = v[10][W-1:0]; bus.c3  = v[11][W-1:0];
  endtask

  task automatic accept_op(input vec12_t v);
    load_ports(v);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    load_ports('{default: 0});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    load_ports('{default: 0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    vectors++; if (bus.singular !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_singular: got %0b expected 0", bus.singular); end
    vectors++; if (bus.x !== DW'(0) || bus.y !== DW'(0) || bus.z !== DW'(0)) begin
      miscompares++; $display("[TB] FAIL reset_xyz: got %0d %0d %0d expected 0 0 0", bus.x, bus.y, bus.z);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_in_ready: got %0b expected 1", bus.in_ready); end
    accept_op(t_basic);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy: got %0b expected 1", bus.busy); end
    wait_done(lat);
    vectors++; if (lat != 127) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 127", lat); end
    vectors++; if (bus.x !== DW'(2)) begin miscompares++; $display("[TB] FAIL basic_x: got %0d expected 2", bus.x); end
    vectors++; if (bus.y !== DW'(3)) begin miscompares++; $display("[TB] FAIL basic_y: got %0d expected 3", bus.y); end
    vectors++; if (bus.z !== DW'(-1)) begin miscompares++; $display("[TB] FAIL basic_z: got %0d expected -1", bus.z); end
    vectors++; if (bus.singular !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_singular: got %0b expected 0", bus.singular); end
    @(posedge clk);
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL basic_release: got out_valid=%0b in_ready=%0b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_singular();
    bus.out_ready = 1'b1;
    accept_op(t_sing);
    wait_done(lat);
    vectors++; if (lat != 13) begin miscompares++; $display("[TB] FAIL singular_latency: got %0d expected 13", lat); end
    vectors++; if (bus.singular !== 1'b1) begin miscompares++; $display("[TB] FAIL singular_flag: got %0b expected 1", bus.singular); end
    vectors++; if (bus.x !== DW'(0) || bus.y !== DW'(0) || bus.z !== DW'(0)) begin
      miscompares++; $display("[TB] FAIL singular_xyz: got %0d %0d %0d expected 0 0 0", bus.x, bus.y, bus.z);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_truncation();
    bus.out_ready = 1'b1;
    accept_op(t_trunc);
    wait_done(lat);
    vectors++; if (lat != 127) begin miscompares++; $display("[TB] FAIL trunc_latency: got %0d expected 127", lat); end
    vectors++; if (bus.singular !== 1'b0) begin miscompares++; $display("[TB] FAIL trunc_singular: got %0b expected 0", bus.singular); end
    vectors++; if (bus.x !== DW'(3)) begin miscompares++; $display("[TB] FAIL trunc_x: got %0d expected 3", bus.x); end
    vectors++; if (bus.y !== DW'(-3)) begin miscompares++; $display("[TB] FAIL trunc_y: got %0d expected -3", bus.y); end
    vectors++; if (bus.z !== DW'(2)) begin miscompares++; $display("[TB] FAIL trunc_z: got %0d expected 2", bus.z); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_scale();
    bus.out_ready = 1'b1;
    accept_op(t_full);
    wait_done(lat);
    vectors++; if (lat != 127) begin miscompares++; $display("[TB] FAIL full_latency: got %0d expected 127", lat); end
    vectors++; if (bus.x !== DW'(-2048)) begin miscompares++; $display("[TB] FAIL full_x: got %0d expected -2048", bus.x); end
    vectors++; if (bus.y !== DW'(2047)) begin miscompares++; $display("[TB] FAIL full_y: got %0d expected 2047", bus.y); end
    vectors++; if (bus.z !== DW'(0)) begin miscompares++; $display("[TB] FAIL full_z: got %0d expected 0", bus.z); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    accept_op(t_basic);
    wait_done(lat);
    vectors++; if (lat != 127) begin miscompares++; $display("[TB] FAIL bp_latency: got %0d expected 127", lat); end
    load_ports(t_trunc);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL bp_hold_ctrl cycle %0d: got out_valid=%0b in_ready=%0b expected 1 0", i, bus.out_valid, bus.in_ready);
      end
      vectors++; if (bus.x !== DW'(2) || bus.y !== DW'(3) || bus.z !== DW'(-1)) begin
        miscompares++; $display("[TB] FAIL bp_hold_xyz cycle %0d: got %0d %0d %0d expected 2 3 -1", i, bus.x, bus.y, bus.z);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_release: got out_valid=%0b in_ready=%0b busy=%0b expected 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid_div();
    bus.out_ready = 1'b1;
    accept_op(t_basic);
    repeat (63) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL middiv_busy: got busy=%0b out_valid=%0b expected 1 0", bus.busy, bus.out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL middiv_ctrl: got busy=%0b out_valid=%0b in_ready=%0b expected 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
    end
    vectors++; if (bus.x !== DW'(0) || bus.y !== DW'(0) || bus.z !== DW'(0)) begin
      miscompares++; $display("[TB] FAIL middiv_xyz: got %0d %0d %0d expected 0 0 0", bus.x, bus.y, bus.z);
    end
    accept_op(t_basic);
    wait_done(lat);
    vectors++; if (lat != 127) begin miscompares++; $display("[TB] FAIL rerun_latency: got %0d expected 127", lat); end
    vectors++; if (bus.x !== DW'(2) || bus.y !== DW'(3) || bus.z !== DW'(-1)) begin
      miscompares++; $display("[TB] FAIL rerun_xyz: got %0d %0d %0d expected 2 3 -1", bus.x, bus.y, bus.z);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed scenario sequence followed by the summary line
  initial begin
    t_basic = '{2, 1, -1, -3, -1, 2, -2, 1, 2, 8, -11, -3};
    t_sing  = '{3, 3, 0, 5, 1, 1, 5, 1, 1, 1, 17, 17};
    t_trunc = '{2, 0, 0, 0, 2, 0, 0, 0, 2, 7, -7, 4};
    t_full  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, -2048, 2047, 0};
    $display("[TB] starting cramer3_seq_ctrl directed tests");
    test_reset();
    test_basic();
    test_singular();
    test_truncation();
    test_full_scale();
    test_backpressure();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
